// File: rtl/pe_feeder_pkg.sv
// Shared types for the attention PE feeder: operand vectors, the buffered K/V pair
// and the feeder state encoding.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif

package pe_feeder_pkg;

  localparam int ELEM_WIDTH = 8;
  localparam int EMBED_DIM  = `MAX_EMBEDDING_DIM;

  typedef logic [EMBED_DIM-1:0][ELEM_WIDTH-1:0] q_vector_t;
  typedef logic [EMBED_DIM-1:0][ELEM_WIDTH-1:0] k_vector_t;
  typedef logic [EMBED_DIM-1:0][ELEM_WIDTH-1:0] v_vector_t;

  typedef struct packed {
    k_vector_t k;
    v_vector_t v;
  } kv_pair_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/pe_feeder_kv_fifo.sv
// Small synchronous FIFO holding prefetched {K,V} rows; DEPTH must be a power of two
// (2 or 4 in practice), pointers wrap modulo DEPTH.
module kv_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// Streams K/V rows for one query from SRAM into the PE, prefetching through kv_fifo
// so the PE sees one q/k/v triple per cycle while it keeps accepting.
module pe_feeder
  import pe_feeder_pkg::*;
#(
  parameter int MAX_SEQ_LEN = 64,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MAX_SEQ_LEN):0] seq_len,
  input  q_vector_t                    q_in,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_rd_en,
  output logic [$clog2(MAX_SEQ_LEN)-1:0] mem_rd_addr,
  input  k_vector_t                    mem_k_data,
  input  v_vector_t                    mem_v_data,
  output logic                         inputs_valid,
  input  logic                         backend_ready,
  output q_vector_t                    q_vector,
  output k_vector_t                    k_vector,
  output v_vector_t                    v_vector,
  output logic                         kv_last
);

  localparam int AW = $clog2(MAX_SEQ_LEN);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  logic [LW-1:0] seq_len_q;
  logic [LW-1:0] rd_addr;
  logic [LW-1:0] sent;
  q_vector_t     q_latched;
  logic          rd_pending;

  kv_pair_t      landing;
  kv_pair_t      head;
  kv_pair_t      fifo_dout;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          accept;

  // Rows already buffered plus the one on the SRAM bus bound how many reads may be issued.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(rd_pending);
  assign mem_rd_en = (state == S_FETCH) && !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign mem_rd_addr = rd_addr[AW-1:0];

  // When the FIFO is empty the row landing from SRAM is presented directly, which gives
  // the one-cycle read-to-valid latency; if it is not taken it is buffered as usual.
  assign landing      = '{k: mem_k_data, v: mem_v_data};
  assign inputs_valid = !fifo_empty || rd_pending;
  assign head         = fifo_empty ? landing : fifo_dout;
  assign accept       = inputs_valid && backend_ready;
  assign fifo_pop     = accept && !fifo_empty;
  assign fifo_push    = rd_pending && !(fifo_empty && accept);

  assign q_vector = q_latched;
  assign k_vector = head.k;
  assign v_vector = head.v;
  assign kv_last  = inputs_valid && (sent == seq_len_q - LW'(1));

  kv_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(kv_pair_t))
  ) u_kv_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (landing),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      seq_len_q  <= '0;
      rd_addr    <= '0;
      sent       <= '0;
      q_latched  <= '0;
      rd_pending <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rd_pending <= mem_rd_en;
      done       <= 1'b0;
      if (mem_rd_en) rd_addr <= rd_addr + LW'(1);
      if (accept)    sent    <= sent + LW'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            seq_len_q <= seq_len;
            q_latched <= q_in;
            rd_addr   <= '0;
            sent      <= '0;
            busy      <= 1'b1;
            if (seq_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (mem_rd_en && (rd_addr + LW'(1) == seq_len_q)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (accept && kv_last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: random SRAM contents and backend stalls, checked
// against an expected row order and cycle-level timing derived from the feeder's rules.
module tb_pe_feeder;
  import pe_feeder_pkg::*;

  localparam int MAX_SEQ_LEN = 64;
  localparam int FIFO_DEPTH  = 2;
  localparam int AW          = $clog2(MAX_SEQ_LEN);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW:0]     seq_len;
  q_vector_t       q_in;
  logic            busy;
  logic            done;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_rd_addr;
  k_vector_t       mem_k_data;
  v_vector_t       mem_v_data;
  logic            inputs_valid;
  logic            backend_ready;
  q_vector_t       q_vector;
  k_vector_t       k_vector;
  v_vector_t       v_vector;
  logic            kv_last;

  k_vector_t       kmem [MAX_SEQ_LEN];
  v_vector_t       vmem [MAX_SEQ_LEN];

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [63:0]     rd_mask;
  logic [63:0]     valid_mask;
  int              last_cycle;
  int              done_cycle;

  pe_feeder #(
    .MAX_SEQ_LEN (MAX_SEQ_LEN),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .seq_len       (seq_len),
    .q_in          (q_in),
    .busy          (busy),
    .done          (done),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_k_data    (mem_k_data),
    .mem_v_data    (mem_v_data),
    .inputs_valid  (inputs_valid),
    .backend_ready (backend_ready),
    .q_vector      (q_vector),
    .k_vector      (k_vector),
    .v_vector      (v_vector),
    .kv_last       (kv_last)
  );

  always #5 clk = ~clk;

  // SRAM model: data is valid only in the cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_k_data <= kmem[mem_rd_addr];
      mem_v_data <= vmem[mem_rd_addr];
    end else begin
      mem_k_data <= k_vector_t'($urandom);
      mem_v_data <= v_vector_t'($urandom);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  function automatic logic readyFor(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return !(c >= 3 && c <= 7);
    endcase
  endfunction

  // Runs one query of n rows; cycle 0 is the cycle in which start is high.
  task automatic applyStimulus(input int n, input int mode, input bit poke);
    q_vector_t q_exp;
    int        reads;
    int        pops;
    int        lasts;
    int        c;
    int        exp_done;
    int        budget;
    bit        finished;

    q_exp = q_vector_t'($urandom);
    for (int i = 0; i < MAX_SEQ_LEN; i++) begin
      kmem[i] = k_vector_t'($urandom);
      vmem[i] = v_vector_t'($urandom);
    end
    rd_mask    = '0;
    valid_mask = '0;
    last_cycle = -1;
    done_cycle = -1;
    reads      = 0;
    pops       = 0;
    lasts      = 0;
    c          = 0;
    finished   = 1'b0;
    budget     = 4 * n + 20;
    exp_done   = (n == 0) ? 1 : -1;

    start         = 1'b1;
    seq_len       = (AW+1)'(n);
    q_in          = q_exp;
    backend_ready = readyFor(mode, 0);

    while (!finished) begin
      @(negedge clk);
      checkOutput("busy", 64'(busy), 64'(c != 0));
      if (mem_rd_en) begin
        checkOutput("rd_addr", 64'(mem_rd_addr), 64'(reads));
        checkOutput("rd_in_range", 64'(reads < n), 64'(1));
        reads++;
        if (c < 64) rd_mask[c] = 1'b1;
      end
      checkOutput("outstanding", 64'((reads - pops) <= FIFO_DEPTH), 64'(1));
      if (inputs_valid) begin
        if (c < 64) valid_mask[c] = 1'b1;
        checkOutput("pop_in_range", 64'(pops < n), 64'(1));
        checkOutput("q_vector", 64'(q_vector), 64'(q_exp));
        checkOutput("k_vector", 64'(k_vector), 64'(kmem[pops % MAX_SEQ_LEN]));
        checkOutput("v_vector", 64'(v_vector), 64'(vmem[pops % MAX_SEQ_LEN]));
        checkOutput("kv_last", 64'(kv_last), 64'(pops == n - 1));
        if (kv_last) last_cycle = c;
        if (backend_ready) begin
          if (kv_last) lasts++;
          pops++;
          if (pops == n) exp_done = c + 1;
        end
      end else begin
        checkOutput("kv_last_idle", 64'(kv_last), 64'(0));
      end
      if (done && done_cycle < 0) done_cycle = c;
      checkOutput("done", 64'(done), 64'(c == exp_done));
      if (c == exp_done) begin
        finished = 1'b1;
      end else if (c >= budget) begin
        checkOutput("done_timeout", 64'(done), 64'(1));
        finished = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        c++;
        start = poke && (c == 3);
        if (poke && c == 3) begin
          seq_len = (AW+1)'(n + 3);
          q_in    = ~q_exp;
        end
        backend_ready = readyFor(mode, c);
      end
    end

    checkOutput("read_count", 64'(reads), 64'(n));
    checkOutput("pop_count", 64'(pops), 64'(n));
    checkOutput("kv_last_count", 64'(lasts), 64'(n > 0));

    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", 64'(busy), 64'(0));
    checkOutput("idle_done", 64'(done), 64'(0));
    checkOutput("idle_valid", 64'(inputs_valid), 64'(0));
    checkOutput("idle_rd_en", 64'(mem_rd_en), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    seq_len       = '0;
    q_in          = '0;
    backend_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_rd_en", 64'(mem_rd_en), 64'(0));
    checkOutput("rst_valid", 64'(inputs_valid), 64'(0));
    checkOutput("rst_kv_last", 64'(kv_last), 64'(0));
    checkOutput("rst_rd_addr", 64'(mem_rd_addr), 64'(0));
    @(posedge clk);
    #1;

    // Minimum-latency run with the backend always ready.
    applyStimulus(4, 0, 1'b0);
    checkOutput("lat_rd_cycles", rd_mask, 64'h1E);
    checkOutput("lat_valid_cycles", valid_mask, 64'h3C);
    checkOutput("lat_kv_last_cycle", 64'(last_cycle), 64'(5));
    checkOutput("lat_done_cycle", 64'(done_cycle), 64'(6));

    // Backend stalled for cycles 3-7.
    applyStimulus(8, 2, 1'b0);

    // Empty query.
    applyStimulus(0, 0, 1'b0);
    checkOutput("empty_rd_cycles", rd_mask, 64'h0);
    checkOutput("empty_valid_cycles", valid_mask, 64'h0);
    checkOutput("empty_done_cycle", 64'(done_cycle), 64'(1));

    // Longest query with random backpressure.
    applyStimulus(MAX_SEQ_LEN, 1, 1'b0);

    // Reset in cycle 4 of a six-row query.
    start         = 1'b1;
    seq_len       = (AW+1)'(6);
    q_in          = q_vector_t'($urandom);
    backend_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_done", 64'(done), 64'(0));
    checkOutput("midrst_rd_en", 64'(mem_rd_en), 64'(0));
    checkOutput("midrst_valid", 64'(inputs_valid), 64'(0));
    checkOutput("midrst_kv_last", 64'(kv_last), 64'(0));
    checkOutput("midrst_rd_addr", 64'(mem_rd_addr), 64'(0));
    @(posedge clk);
    #1;
    applyStimulus(6, 1, 1'b0);

    // start pulsed (with different seq_len and q) while busy must be ignored.
    applyStimulus(5, 1, 1'b1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus($urandom_range(1, 12), 1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter MAX_SEQ_LEN, default 64: maximum K/V rows per query.
REQ-002 Parameter FIFO_DEPTH, default 2: prefetch buffer entries; legal values are 2 or 4.
REQ-003 clk  in  1  system clock; all logic is on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begin one query; sampled only in IDLE.
REQ-006 seq_len  in  $clog2(MAX_SEQ_LEN)+1  number of K/V rows; sampled with start.
REQ-007 q_in  in  Q_VECTOR_T  query vector; sampled with start.
REQ-008 busy  out  1  high in every state other than IDLE.
REQ-009 done  out  1  one-cycle pulse after the last row is accepted by the PE.
REQ-010 mem_rd_en  out  1  K/V SRAM read strobe.
REQ-011 mem_rd_addr  out  $clog2(MAX_SEQ_LEN)  row address.
REQ-012 mem_k_data  in  K_VECTOR_T  K row; valid exactly 1 cycle after mem_rd_en.
REQ-013 mem_v_data  in  V_VECTOR_T  V row; same timing as mem_k_data.
REQ-014 inputs_valid  out  1  a q/k/v triple is presented to the PE.
REQ-015 backend_ready  in  1  the PE accepts the triple this cycle.
REQ-016 q_vector, k_vector, v_vector  out  Q/K/V_VECTOR_T  operands to the PE.
REQ-017 kv_last  out  1  qualifies inputs_valid; marks the final row of the query.

Function
REQ-018 States: IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE with start=1 and seq_len>0: latch q_in and seq_len, clear the read address and sent counters, go to FETCH.
REQ-020 IDLE with start=1 and seq_len=0: go directly to DONE and issue no reads.
REQ-021 FETCH: assert mem_rd_en when (FIFO occupancy + reads in flight) < FIFO_DEPTH.
REQ-022 Each read increments the read address; the block never issues more than FIFO_DEPTH outstanding entries, so the FIFO never overflows.
REQ-023 FETCH to DRAIN when the read address reaches seq_len after the last read.
REQ-024 Data returned 1 cycle after mem_rd_en is pushed into the FIFO as a {K,V} pair, even when backend_ready=0.
REQ-025 inputs_valid = FIFO not empty; k_vector and v_vector come from the FIFO head; q_vector is the latched query.
REQ-026 A pop occurs on inputs_valid & backend_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-027 kv_last = inputs_valid & (sent counter == seq_len-1).
REQ-028 DRAIN to DONE on the pop that carries kv_last.
REQ-029 DONE: assert done for 1 cycle, then return to IDLE.
REQ-030 start is ignored while busy.
REQ-031 The outputs stay stable while inputs_valid=1 and backend_ready=0.
REQ-032 Minimum latency, with backend_ready held high: start (cycle 0), first mem_rd_en (cycle 1), first inputs_valid (cycle 2).
REQ-033 Sustained throughput is 1 row/cycle.
REQ-034 The FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-035 On rst: state=IDLE; busy, done, mem_rd_en, inputs_valid, kv_last = 0; mem_rd_addr=0; FIFO empty; counters=0.
REQ-036 rst mid-query takes effect at the next edge, abandons the query, and discards any in-flight read data.

Structure
REQ-037 Q_VECTOR_T, K_VECTOR_T, V_VECTOR_T and `MAX_EMBEDDING_DIM come from the shared package, and the state enum is added to that package.
REQ-038 The FIFO is one sub-module, kv_fifo (parameterised depth, with a push/pop/full/empty/count interface).

Verification
REQ-039 seq_len=4, backend_ready=1 -> mem_rd_en cycles 1-4, inputs_valid cycles 2-5, kv_last in cycle 5, done in cycle 6.
REQ-040 seq_len=8, backend_ready low for cycles 3-7 -> no more than 2 reads outstanding, no triple lost or duplicated, order matches addresses 0-7.
REQ-041 seq_len=0 -> done 1 cycle after start, and mem_rd_en and inputs_valid never asserted.
REQ-042 seq_len=MAX_SEQ_LEN=64 with random backend_ready -> 64 pops, addresses 0-63, exactly one kv_last, FIFO wraps without error.
REQ-043 rst at cycle 4 of a seq_len=6 query -> next cycle all outputs at reset values; a new start then runs correctly from address 0.
REQ-044 start pulsed while busy -> the latched q and seq_len are unchanged and the query completes normally.
